// File: rtl/pipe_hazard_unit_if.sv
// Bundle of pipeline-register fields the hazard unit watches and the controls it drives.
// The pipeline side uses the master modport; the hazard unit uses the slave modport.
interface pipe_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                        EXMEMWr;
  logic [REG_AW-1:0]           EXMEMRd;
  logic                        MEMWBWr;
  logic [REG_AW-1:0]           MEMWBRd;
  logic [NUM_SRC*REG_AW-1:0]   IDEXSrc;
  logic                        IDEXMemRd;
  logic                        IDEXWr;
  logic [REG_AW-1:0]           IDEXRd;
  logic [NUM_SRC*REG_AW-1:0]   IFIDSrc;
  logic [NUM_SRC-1:0]          IFIDUse;
  logic                        flush;
  logic [2*NUM_SRC-1:0]        forward;
  logic                        stall;
  logic                        bubble;
  logic [CNT_W-1:0]            stall_cnt;

  modport master (
    output EXMEMWr, EXMEMRd, MEMWBWr, MEMWBRd, IDEXSrc, IDEXMemRd, IDEXWr, IDEXRd,
           IFIDSrc, IFIDUse, flush,
    input  forward, stall, bubble, stall_cnt
  );

  modport slave (
    input  EXMEMWr, EXMEMRd, MEMWBWr, MEMWBRd, IDEXSrc, IDEXMemRd, IDEXWr, IDEXRd,
           IFIDSrc, IFIDUse, flush,
    output forward, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Data-hazard controller: EX-stage operand forwarding plus a load-use stall FSM
// that holds PC/IF-ID and bubbles ID/EX for LOAD_LAT cycles per hazard.
module pipe_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_unit_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [3:0]       HOLD_INIT = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // EX/MEM holds the younger result, so it wins over MEM/WB; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              exmem_wr,
    input logic [REG_AW-1:0] exmem_rd,
    input logic              memwb_wr,
    input logic [REG_AW-1:0] memwb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (exmem_wr && (exmem_rd != '0) && (exmem_rd == src))
      sel = 2'b10;
    else if (memwb_wr && (memwb_rd != '0) && (memwb_rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  state_t               state, state_nx;
  logic [3:0]           hcnt, hcnt_nx;
  logic [2*NUM_SRC-1:0] fwd;
  logic                 use_hit;
  logic                 hazard;
  logic                 stall_c;
  logic [CNT_W-1:0]     cnt;

  always_comb begin
    fwd = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd[2*k +: 2] = fwd_sel(bus.IDEXSrc[k*REG_AW +: REG_AW],
                              bus.EXMEMWr, bus.EXMEMRd, bus.MEMWBWr, bus.MEMWBRd);
    end
  end

  always_comb begin
    use_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.IFIDUse[k] && (bus.IFIDSrc[k*REG_AW +: REG_AW] == bus.IDEXRd))
        use_hit = 1'b1;
    end
  end

  assign hazard = bus.IDEXMemRd && bus.IDEXWr && (bus.IDEXRd != '0) && use_hit;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hcnt  <= '0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
    end
  end

  // Next-state logic; flush overrides any stall in progress.
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    if (bus.flush) begin
      state_nx = IDLE;
      hcnt_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state_nx = HOLD;
            hcnt_nx  = HOLD_INIT;
          end
        end
        HOLD: begin
          hcnt_nx = hcnt - 4'd1;
          if (hcnt == 4'd1)
            state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
          hcnt_nx  = '0;
        end
      endcase
    end
  end

  // Output logic; the first stall cycle is issued from IDLE, the rest from HOLD.
  always_comb begin
    stall_c = 1'b0;
    if (reset && !bus.flush) begin
      case (state)
        IDLE:    stall_c = hazard;
        HOLD:    stall_c = 1'b1;
        default: stall_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (stall_c)
      cnt <= sat_inc(cnt);
  end

  assign bus.forward   = reset ? fwd : '0;
  assign bus.stall     = stall_c;
  assign bus.bubble    = stall_c;
  assign bus.stall_cnt = cnt;

endmodule
